// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a 32-bit word memory: sub-word store RMW, load lane extract, misalign errors.
// Optional macro DMEM_ARB_RR_EN selects round-robin tie-breaking; default build is fixed priority (req0 wins).
module dmem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_write,
    input  logic [1:0]               req0_size,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_write,
    input  logic [1:0]               req1_size,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    output logic                     rsp0_valid,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_write_enable,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

    state_t                   state;
    logic                     write_q;
    logic [1:0]               size_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    merged_q;
    logic                     owner_q;

    logic                     grant0;
    logic                     grant1;
    logic                     misaligned;
    logic [DATA_WIDTH-1:0]    load_lane;
    logic [DATA_WIDTH-1:0]    merge_word;

`ifdef DMEM_ARB_RR_EN
    logic last_grant;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid && !req0_valid;
`endif

    assign req0_ready = rst_n && (state == IDLE) && grant0;
    assign req1_ready = rst_n && (state == IDLE) && grant1;
    assign rsp0_valid = (state == RESP) && !owner_q;
    assign rsp1_valid = (state == RESP) && owner_q;

    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = (addr_q[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Load lanes are zero-extended; store lanes overwrite the word just read.
    always_comb begin
        load_lane  = '0;
        merge_word = mem_read_data;
        case (size_q)
            2'b00: begin
                load_lane[7:0] = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
                merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_lane[15:0] = mem_read_data[{addr_q[1], 4'b0000} +: 16];
                merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: load_lane = mem_read_data;
        endcase
    end

    assign mem_address    = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
    assign mem_write_data = (state == MERGE_WR) ? merged_q : wdata_q;
    // NOTE: rst_n gates the write strobe combinationally so an op cut short by reset cannot corrupt memory.
    assign mem_write_enable = rst_n &&
        (((state == ACCESS) && write_q && (size_q == 2'b10) && !misaligned) ||
         (state == MERGE_WR));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            merged_q  <= '0;
            owner_q   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        write_q <= grant1 ? req1_write : req0_write;
                        size_q  <= grant1 ? req1_size  : req0_size;
                        addr_q  <= grant1 ? req1_addr  : req0_addr;
                        wdata_q <= grant1 ? req1_wdata : req0_wdata;
                        owner_q <= grant1;
                        state   <= ACCESS;
`ifdef DMEM_ARB_RR_EN
                        last_grant <= grant1;
`endif
                    end
                end
                ACCESS: begin
                    rsp_rdata <= '0;
                    rsp_err   <= misaligned;
                    if (misaligned) begin
                        state <= RESP;
                    end else if (!write_q) begin
                        rsp_rdata <= load_lane;
                        state     <= RESP;
                    end else if (size_q == 2'b10) begin
                        state <= RESP;
                    end else begin
                        merged_q <= merge_word;
                        state    <= MERGE_WR;
                    end
                end
                MERGE_WR: state <= RESP;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses/writes; a monitor compares them.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [1:0]  req0_size = 2'b10;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [1:0]  req1_size = 2'b10;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, mem_write_enable;
    logic [31:0] rsp_rdata, mem_address, mem_write_data, mem_read_data;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_size(req0_size), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_size(req1_size), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int port; logic [31:0] rdata; logic err; int at;} rsp_t;
    typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
    rsp_t rq[$];
    wr_t  wq[$];

    int total = 0;
    int bad = 0;
    logic tb_last = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every response pulse and memory write against the queued expectations.
    always @(negedge clk) begin
        if (mem_write_enable) begin
            if (wq.size() == 0) check("unexpected_write", mem_address, 32'hFFFF_FFFF);
            else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", mem_address, w.addr);
                check("wr_data", mem_write_data, w.data);
            end
        end
        if (rst_n) begin
            if (req0_ready && req1_ready) check("dual_ready", 32'd1, 32'd0);
            if (rsp0_valid && rsp1_valid) check("dual_rsp", 32'd1, 32'd0);
            if (rsp0_valid || rsp1_valid) begin
                if (rq.size() == 0) check("unexpected_rsp", rsp_rdata, 32'hFFFF_FFFF);
                else begin
                    rsp_t e;
                    e = rq.pop_front();
                    check("rsp_port", {31'd0, rsp1_valid}, 32'(e.port));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    check("rsp_cycle", 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    task automatic drive(input int p, input logic v, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            req0_valid = v; req0_write = w; req0_size = sz; req0_addr = a; req0_wdata = wd;
        end else begin
            req1_valid = v; req1_write = w; req1_size = sz; req1_addr = a; req1_wdata = wd;
        end
    endtask

    // Issues one request, waits (bounded) for the handshake and queues the expected response.
    task automatic req(input int p, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input bit expect_rsp);
        int n;
        logic rdy;
        @(posedge clk) #1;
        drive(p, 1'b1, w, sz, a, wd);
        n = 0;
        @(negedge clk);
        rdy = (p == 0) ? req0_ready : req1_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = (p == 0) ? req0_ready : req1_ready;
            n++;
        end
        if (!rdy) check("handshake_timeout", 32'd0, 32'd1);
        else begin
            tb_last = (p != 0);
            if (expect_rsp) rq.push_back('{port: p, rdata: er, err: ee, at: cyc + lat});
        end
        @(posedge clk) #1;
        drive(p, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (rq.size() == 0 && wq.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(rq.size() + wq.size()), 32'd0);
    endtask

    initial begin
        int   grants;
        logic g, exp_g;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Reset with a pending request: nothing may be accepted or answered.
        drive(0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
        check("rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_we", {31'd0, mem_write_enable}, 32'd0);
        @(posedge clk) #1;
        drive(0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Word store and load back.
        wq.push_back('{addr: 32'h10, data: 32'hDEADBEEF});
        req(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1); wait_idle();
        req(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1); wait_idle();

        // Byte store read-modify-write and byte load.
        wq.push_back('{addr: 32'h20, data: 32'h11223344});
        req(0, 1'b1, 2'b10, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1'b1); wait_idle();
        wq.push_back('{addr: 32'h20, data: 32'h11AA3344});
        req(0, 1'b1, 2'b00, 32'h22, 32'h000000AA, 32'h0, 1'b0, 3, 1'b1); wait_idle();
        req(0, 1'b0, 2'b00, 32'h22, 32'h0, 32'h000000AA, 1'b0, 2, 1'b1); wait_idle();

        // Misaligned half store: error, no write, memory unchanged.
        req(0, 1'b1, 2'b01, 32'h21, 32'h0000BEEF, 32'h0, 1'b1, 2, 1'b1); wait_idle();
        check("mem_after_err", mem[8], 32'h11AA3344);
        req(0, 1'b0, 2'b10, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 2, 1'b1); wait_idle();

        // req1 alone: half store, half/byte loads, illegal size, misaligned word.
        wq.push_back('{addr: 32'h10, data: 32'hCAFEBEEF});
        req(1, 1'b1, 2'b01, 32'h12, 32'h0000CAFE, 32'h0, 1'b0, 3, 1'b1); wait_idle();
        req(1, 1'b0, 2'b01, 32'h12, 32'h0, 32'h0000CAFE, 1'b0, 2, 1'b1); wait_idle();
        req(1, 1'b0, 2'b00, 32'h11, 32'h0, 32'h000000BE, 1'b0, 2, 1'b1); wait_idle();
        req(1, 1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1, 2, 1'b1); wait_idle();
        req(1, 1'b1, 2'b10, 32'h12, 32'h12345678, 32'h0, 1'b1, 2, 1'b1); wait_idle();
        check("mem_after_req1", mem[4], 32'hCAFEBEEF);

        // Both requesters valid continuously: four grants.
        @(posedge clk) #1;
        drive(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        grants = 0;
        for (int k = 0; k < 60 && grants < 4; k++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                g = req1_ready;
`ifdef DMEM_ARB_RR_EN
                exp_g = !tb_last;
`else
                exp_g = 1'b0;
`endif
                check("grant", {31'd0, g}, {31'd0, exp_g});
                rq.push_back('{port: int'(g), rdata: 32'hCAFEBEEF, err: 1'b0, at: cyc + 2});
                tb_last = g;
                grants++;
            end
        end
        check("grant_count", 32'(grants), 32'd4);
        @(posedge clk) #1;
        drive(0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
        wait_idle();

        // Reset during MERGE_WR of a byte store: no write, no response.
        req(0, 1'b1, 2'b00, 32'h23, 32'h00000055, 32'h0, 1'b0, 3, 1'b0);
        @(posedge clk) #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_merge_we", {31'd0, mem_write_enable}, 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        tb_last = 1'b1;
        repeat (4) @(negedge clk);
        check("mem_after_drop", mem[8], 32'h11AA3344);
        req(0, 1'b0, 2'b00, 32'h23, 32'h0, 32'h00000011, 1'b0, 2, 1'b1); wait_idle();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
